// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing helpers for the data-memory arbiter.
// Holds no state; everything here is elaborated at compile time.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      REQ_M0   = 2'd0,
      REQ_M1   = 2'd1,
      REQ_NONE = 2'd2
   } req_id_e;

   localparam int unsigned DMEM_DEPTH_DFLT = 1024;

   function automatic int unsigned wait_cnt_w(input int unsigned max_wait);
      return $clog2(max_wait + 1);
   endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// One requester port of the data-memory arbiter: request/grant plus registered read response.
// The requester holds req/we/addr/wdata stable until it samples gnt=1.
interface dmem_arb_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   logic              err;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arb_pick.sv
// Winner selection: M0 has fixed priority unless M1 has already waited MAX_WAIT cycles.
// Purely combinational, zero latency.
module dmem_arb_pick
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned CNT_W    = wait_cnt_w(MAX_WAIT)
) (
   input  logic             m0_req_i,
   input  logic             m1_req_i,
   input  logic [CNT_W-1:0] wait_cnt_i,
   output req_id_e          winner_o
);

   always_comb begin
      winner_o = REQ_NONE;
      if (m0_req_i && m1_req_i) begin
         winner_o = (wait_cnt_i == CNT_W'(MAX_WAIT)) ? REQ_M1 : REQ_M0;
      end else if (m0_req_i) begin
         winner_o = REQ_M0;
      end else if (m1_req_i) begin
         winner_o = REQ_M1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory; grant in 0 cycles, read data 1 cycle later.
// Optional bounds checking under DMEM_ARB_BOUNDS_CHECK_EN suppresses out-of-range accesses and flags err.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DEPTH    = DMEM_DEPTH_DFLT,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   dmem_arb_if.slave         m0_io,
   dmem_arb_if.slave         m1_io,
   output logic              mem_write_o,
   output logic              mem_read_o,
   output logic [ADDR_W-1:0] address_o,
   output logic [DATA_W-1:0] write_data_o,
   input  logic [DATA_W-1:0] read_data_i
);

   localparam int unsigned CNT_W = wait_cnt_w(MAX_WAIT);

   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   req_id_e           pick_id, winner;
   logic              win_we, win_oob;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata, rd_data;
   logic              m0_oob, m1_oob;
   logic [1:0]        rvalid_q, rvalid_d, err_q, err_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
   assign m0_oob = (m0_io.addr >= ADDR_W'(DEPTH));
   assign m1_oob = (m1_io.addr >= ADDR_W'(DEPTH));
`else
   assign m0_oob = 1'b0;
   assign m1_oob = 1'b0;
`endif

   dmem_arb_pick #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_pick (
      .m0_req_i   (m0_io.req),
      .m1_req_i   (m1_io.req),
      .wait_cnt_i (wait_cnt_q),
      .winner_o   (pick_id)
   );

   // Reset masks the grant so nothing reaches memory or the response registers.
   assign winner = rst_ni ? pick_id : REQ_NONE;

   always_comb begin
      win_we    = 1'b0;
      win_oob   = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      case (winner)
         REQ_M0: begin
            win_we    = m0_io.we;
            win_oob   = m0_oob;
            win_addr  = m0_io.addr;
            win_wdata = m0_io.wdata;
         end
         REQ_M1: begin
            win_we    = m1_io.we;
            win_oob   = m1_oob;
            win_addr  = m1_io.addr;
            win_wdata = m1_io.wdata;
         end
         default: ;
      endcase
   end

   assign m0_io.gnt    = (winner == REQ_M0);
   assign m1_io.gnt    = (winner == REQ_M1);
   assign mem_write_o  = (winner != REQ_NONE) &&  win_we && !win_oob;
   assign mem_read_o   = (winner != REQ_NONE) && !win_we && !win_oob;
   assign address_o    = win_addr;
   assign write_data_o = win_wdata;
   assign rd_data      = win_oob ? '0 : read_data_i;

   always_comb begin
      wait_cnt_d = '0;
      if (m1_io.req && (winner != REQ_M1)) begin
         wait_cnt_d = (wait_cnt_q == CNT_W'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
      end
   end

   always_comb begin
      rvalid_d = '0;
      err_d    = '0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (winner)
         REQ_M0: begin
            rvalid_d[0] = !win_we;
            err_d[0]    = win_oob;
            if (!win_we) rdata0_d = rd_data;
         end
         REQ_M1: begin
            rvalid_d[1] = !win_we;
            err_d[1]    = win_oob;
            if (!win_we) rdata1_d = rd_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wait_cnt_q <= '0;
         rvalid_q   <= '0;
         err_q      <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end

   assign m0_io.rvalid = rvalid_q[0];
   assign m1_io.rvalid = rvalid_q[1];
   assign m0_io.rdata  = rdata0_q;
   assign m1_io.rdata  = rdata1_q;
   assign m0_io.err    = err_q[0];
   assign m1_io.err    = err_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter with a reference memory and response scoreboard.
`timescale 1ns/1ps
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int DATA_W = 32, ADDR_W = 32, DEPTH = 1024, MAX_WAIT = 4, MEM_SZ = 2048;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } op_t;
   typedef struct { int due; logic is_rd; logic [DATA_W-1:0] data; logic err; } rsp_t;

   logic clk = 1'b0;
   logic rst_n, rst_next, mem_ready, mon_en;
   logic mem_write, mem_read;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] write_data, read_data;
   logic [DATA_W-1:0] mem     [MEM_SZ];
   logic [DATA_W-1:0] ref_mem [MEM_SZ];

   op_t  q0[$], q1[$];
   rsp_t e0[$], e1[$];
   int   glog[$];
   int   checks = 0, failures = 0, cyc = 0, m_wait = 0;

   dmem_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) m0_if ();
   dmem_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) m1_if ();

   dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .m0_io        (m0_if),
      .m1_io        (m1_if),
      .mem_write_o  (mem_write),
      .mem_read_o   (mem_read),
      .address_o    (address),
      .write_data_o (write_data),
      .read_data_i  (read_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DATA_W-1:0] init_val(input int i);
      return (i == 5) ? 32'h0000_00AA : {16'hC0DE, 16'(i)};
   endfunction

   function automatic op_t mk_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      op_t o;
      o.we = we; o.addr = a; o.data = d;
      return o;
   endfunction

   // Memory model seen by the DUT: combinational read, write committed at the edge.
   assign read_data = (address < MEM_SZ) ? mem[address[10:0]] : '0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < MEM_SZ; i++) mem[i] <= init_val(i);
      end else if (mem_write && address < MEM_SZ) begin
         mem[address[10:0]] <= write_data;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   // One clock: present queue heads, predict the winner from the arbitration rules, record responses.
   task automatic step();
      op_t  op;
      int   w;
      logic r0, r1, oob;
      logic [DATA_W-1:0] rd;
      @(posedge clk); #1;
      rst_n = rst_next;
      r0 = (q0.size() > 0);
      r1 = (q1.size() > 0);
      op = r0 ? q0[0] : mk_op(1'b0, '0, '0);
      m0_if.req = r0; m0_if.we = op.we; m0_if.addr = op.addr; m0_if.wdata = op.data;
      op = r1 ? q1[0] : mk_op(1'b0, '0, '0);
      m1_if.req = r1; m1_if.we = op.we; m1_if.addr = op.addr; m1_if.wdata = op.data;
      @(negedge clk);
      if (!rst_n)          w = 2;
      else if (r0 && r1)   w = (m_wait >= MAX_WAIT) ? 1 : 0;
      else if (r0)         w = 0;
      else if (r1)         w = 1;
      else                 w = 2;
      glog.push_back(w);
      chk("m0_gnt", m0_if.gnt, w == 0);
      chk("m1_gnt", m1_if.gnt, w == 1);
      op = (w == 0) ? q0[0] : (w == 1) ? q1[0] : mk_op(1'b0, '0, '0);
      oob = BC && (op.addr >= DEPTH);
      chk("mem_write", mem_write, (w != 2) && op.we && !oob);
      chk("mem_read", mem_read, (w != 2) && !op.we && !oob);
      chk("address", address, op.addr);
      chk("write_data", write_data, op.data);
      if (w != 2) begin
         if (op.we && !oob) ref_mem[op.addr[10:0]] = op.data;
         if (!op.we || oob) begin
            rd = oob ? '0 : ref_mem[op.addr[10:0]];
            if (w == 0) e0.push_back('{cyc + 1, !op.we, rd, oob});
            else        e1.push_back('{cyc + 1, !op.we, rd, oob});
         end
         if (w == 0) void'(q0.pop_front());
         else        void'(q1.pop_front());
      end
      if (!rst_n)              m_wait = 0;
      else if (r1 && w != 1)   m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else                     m_wait = 0;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((q0.size() + q1.size() + e0.size() + e1.size()) > 0 && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL %s_timeout cyc=%0d actual=%0d pending expected=0", name, cyc,
                  q0.size() + q1.size() + e0.size() + e1.size());
      end
   endtask

   task automatic mon_one(input int m, input logic rv, input logic [DATA_W-1:0] rdat, input logic er);
      rsp_t r;
      bit   have;
      have = (m == 0) ? (e0.size() > 0) : (e1.size() > 0);
      if (have) r = (m == 0) ? e0[0] : e1[0];
      if (rv || er) begin
         if (!have || r.due != cyc) begin
            checks++; failures++;
            $display("FAIL m%0d_unexpected_rsp cyc=%0d actual rvalid=%0b err=%0b expected none", m, cyc, rv, er);
         end else begin
            if (m == 0) void'(e0.pop_front());
            else        void'(e1.pop_front());
            chk((m == 0) ? "m0_rvalid" : "m1_rvalid", rv, r.is_rd);
            if (r.is_rd) chk((m == 0) ? "m0_rdata" : "m1_rdata", rdat, r.data);
            chk((m == 0) ? "m0_err" : "m1_err", er, r.err);
         end
      end else if (have && r.due <= cyc) begin
         checks++; failures++;
         $display("FAIL m%0d_missing_rsp cyc=%0d actual none expected rvalid=%0b err=%0b", m, cyc, r.is_rd, r.err);
         if (m == 0) void'(e0.pop_front());
         else        void'(e1.pop_front());
      end
   endtask

   initial begin
      forever begin
         @(posedge clk); #2;
         if (mon_en) begin
            mon_one(0, m0_if.rvalid, m0_if.rdata, m0_if.err);
            mon_one(1, m1_if.rvalid, m1_if.rdata, m1_if.err);
         end
      end
   end

   initial begin
      int pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      int base;
      rst_n = 1'b0; rst_next = 1'b0; mem_ready = 1'b0; mon_en = 1'b0;
      m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
      m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
      for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = init_val(i);

      step();
      mem_ready = 1'b1;
      step();
      chk("rst_m0_rvalid", m0_if.rvalid, 0);
      chk("rst_m1_rvalid", m1_if.rvalid, 0);
      chk("rst_m0_err", m0_if.err, 0);
      chk("rst_m1_err", m1_if.err, 0);
      chk("rst_m0_rdata", m0_if.rdata, 0);
      chk("rst_m1_rdata", m1_if.rdata, 0);
      rst_next = 1'b1;
      mon_en = 1'b1;

      q0.push_back(mk_op(1'b0, 5, 32'h0));
      drain("single_read", 20);

      q1.push_back(mk_op(1'b1, 7, 32'hDEAD_BEEF));
      q1.push_back(mk_op(1'b0, 7, 32'h0));
      drain("write_read", 20);

      step(); step();
      base = glog.size();
      for (int i = 0; i < 10; i++) begin
         q0.push_back(mk_op(1'b0, 32'(i), 32'h0));
         q1.push_back(mk_op(1'b0, 32'(i + 16), 32'h0));
      end
      for (int i = 0; i < 10; i++) step();
      for (int i = 0; i < 10; i++) chk("contention_winner", glog[base + i], pat[i]);
      drain("contention", 40);

      step();
      q1.push_back(mk_op(1'b0, 3, 32'h0));
      q1.push_back(mk_op(1'b0, 4, 32'h0));
      base = glog.size();
      step();
      q0.push_back(mk_op(1'b0, 5, 32'h0));
      step();
      chk("arrival_first", glog[base], 1);
      chk("arrival_second", glog[base + 1], 0);
      drain("arrival", 20);

      for (int i = 0; i < 6; i++) q0.push_back(mk_op(1'b0, 5, 32'h0));
      for (int i = 0; i < 2; i++) q1.push_back(mk_op(1'b0, 7, 32'h0));
      for (int i = 0; i < 4; i++) step();
      rst_next = 1'b0;
      step();
      rst_next = 1'b1;
      base = glog.size();
      step();
      chk("post_reset_winner", glog[base], 0);
      drain("reset_mid_read", 30);

      q1.push_back(mk_op(1'b1, 1024, 32'h1234_5678));
      q1.push_back(mk_op(1'b0, 1025, 32'h0));
      drain("bounds", 20);
      chk("bounds_mem", mem[1024], BC ? init_val(1024) : 32'h1234_5678);

      for (int c = 0; c < 600; c++) begin
         if (q0.size() == 0 && $urandom_range(0, 99) < 60)
            q0.push_back(mk_op(1'($urandom_range(0, 1)),
                               ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1020, 1030)) : 32'($urandom_range(0, 15)),
                               $urandom));
         if (q1.size() == 0 && $urandom_range(0, 99) < 60)
            q1.push_back(mk_op(1'($urandom_range(0, 1)),
                               ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1020, 1030)) : 32'($urandom_range(0, 15)),
                               $urandom));
         rst_next = ($urandom_range(0, 99) != 0);
         step();
      end
      rst_next = 1'b1;
      drain("random", 60);
      chk("m0_rsp_queue_empty", e0.size(), 0);
      chk("m1_rsp_queue_empty", e1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port, word-addressed data memory. It shares the memory between the CPU load/store path (M0) and a secondary master such as a DMA or debug loader (M1). It grants at most one access per cycle, drives the memory control/address/data lines, and returns registered read data to the winner. M0 has fixed priority, with a starvation counter guaranteeing M1 progress.

## Interface
- `DATA_W`, 32, data word width
- `ADDR_W`, 32, address width (word index, not byte address)
- `DEPTH`, 1024, memory words; used by bounds check
- `MAX_WAIT`, 4, consecutive M0 wins tolerated while M1 waits; range 1..15
- `CLK` input 1: single clock, all state on rising edge
- `RST_N` input 1: synchronous, active-low reset
- `M0_REQ`, `M1_REQ` input 1: access request
- `M0_WE`, `M1_WE` input 1: 1 = write, 0 = read
- `M0_ADDR`, `M1_ADDR` input ADDR_W: word address
- `M0_WDATA`, `M1_WDATA` input DATA_W: write data
- `M0_GNT`, `M1_GNT` output 1: request accepted this cycle (combinational)
- `M0_RVALID`, `M1_RVALID` output 1: read data valid, one-cycle pulse
- `M0_RDATA`, `M1_RDATA` output DATA_W: registered read data
- `M0_ERR`, `M1_ERR` output 1: out-of-range flag, pulses with RVALID or one cycle after a write grant
- `MemWrite`, `MemRead` output 1: memory strobes
- `Address` output ADDR_W: memory address
- `WriteData` output DATA_W: memory write data
- `ReadData` input DATA_W: combinational memory read data

## Operation
- Requester handshake:
  - The requester holds REQ, WE, ADDR and WDATA stable until it samples GNT=1.
  - The next access may be presented in the cycle after GNT.
- Winner selection, each cycle:
  - Only one REQ high: that requester wins.
  - Both REQ high and `wait_cnt == MAX_WAIT`: M1 wins.
  - Both REQ high otherwise: M0 wins.
- Starvation counter `wait_cnt`:
  - Increments when M1_REQ=1 and M1 is not granted.
  - Clears when M1 is granted or M1_REQ=0.
  - Saturates at MAX_WAIT.
- Memory drive:
  - Address, WriteData, MemWrite and MemRead are muxed combinationally from the winner.
  - MemWrite = winner WE; MemRead = winner ~WE.
  - With no winner, all memory outputs are 0.
- Read return:
  - At the edge ending a read grant, ReadData is captured into the winner's RDATA.
  - That winner's RVALID is 1 for exactly the following cycle.
  - RDATA holds its value until the next read by that requester.
- Writes produce no RVALID; the memory commits the write at the edge ending the grant cycle.
- Reset (RST_N=0 sampled at an edge):
  - wait_cnt=0, RVALID=0, ERR=0, RDATA=0.
  - While RST_N=0, GNT and all memory strobes are forced 0.
  - A read granted in the cycle reset is sampled produces no RVALID.

## Timing
- Grant latency 0 cycles: GNT is in the same cycle as REQ when the requester wins.
- Read latency 1 cycle: RVALID/RDATA arrive in the cycle after GNT.
- Throughput: one access per cycle, with no bubble between back-to-back grants to either master.
- Read in the cycle after a write to the same address returns the new data.
- Both masters continuously requesting with MAX_WAIT=N: grant pattern repeats N×M0, 1×M1.
- ERR timing matches RVALID for reads, and is one cycle after GNT for writes.

## Configuration
- `DMEM_ARB_BOUNDS_CHECK_EN` defined:
  - A grant with ADDR ≥ DEPTH still returns GNT.
  - The memory access itself is suppressed: MemWrite=0 and MemRead=0.
  - A read returns RDATA=0 with RVALID.
  - The requester's ERR pulses one cycle after GNT.
- `DMEM_ARB_BOUNDS_CHECK_EN` undefined:
  - ERR outputs are tied 0.
  - The address passes through unchecked.

## Structure
- Package `dmem_arb_pkg` holds:
  - requester ID enum (`REQ_M0`, `REQ_M1`, `REQ_NONE`)
  - default DEPTH constant
  - wait-counter width function (clog2 of MAX_WAIT+1)
- Sub-module `dmem_arb_pick`: pure selection logic taking REQ pair, wait_cnt and MAX_WAIT, returning the winner ID.
- Top level holds the counter, muxes and response registers.

## Test plan
- Single reads: M0 read addr 5 (memory 0x0000_00AA) → M0_GNT same cycle, M0_RVALID next cycle with M0_RDATA=0xAA; M1 outputs idle.
- Write then read: M1 write addr 7 data 0xDEAD_BEEF, next cycle M1 read addr 7 → RDATA=0xDEADBEEF one cycle later.
- Contention, MAX_WAIT=4: both REQ held for 10 cycles → grants M0,M0,M0,M0,M1,M0,M0,M0,M0,M1; wait_cnt returns to 0 after each M1 grant.
- Simultaneous arrival with M1 pending: M1_REQ alone 1 cycle, then both → M1 granted the first cycle, M0 the second.
- Reset mid-read: RST_N low in the grant cycle of an M0 read → no M0_RVALID, wait_cnt=0, MemWrite=0 throughout reset.
- Bounds, with macro: M1 write addr 1024 → GNT=1, MemWrite=0, M1_ERR pulse next cycle, memory unchanged. Without macro: M1_ERR stays 0.
